// File: rtl/m_pkg.sv
// Shared types for the data-bus controller: FSM states, the latched request
// record and the default bus timeout.
package m_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    DONE  = 3'd3,
    FLUSH = 3'd4
  } dbus_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } dbus_req_t;

  localparam int unsigned DBUS_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/m_dbus_ctrl.sv
// Data-bus controller: turns level-held LSU load/store/dcache-flush requests
// into one outstanding req/gnt/rvalid transaction and a one-cycle ack.
module m_dbus_ctrl
  import m_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DBUS_TIMEOUT_DEFAULT,
  parameter int unsigned FLUSH_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu2dbus_ld_req,
  input  logic        lsu2dbus_st_req,
  input  logic [31:0] dbus_addr,
  input  logic [3:0]  lsu2dbus_byte_enable,
  input  logic [31:0] lsu2dbus_W_data,
  input  logic        dcache_flush,
  input  logic        lsu_flush,
  output logic [31:0] dbus_rdata,
  output logic        dbus_ack,
  output logic        dbus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output dbus_state_e state_dbg
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

  dbus_state_e   state_q, state_d;
  dbus_req_t     req_q, req_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [FW-1:0] fl_cnt_q, fl_cnt_d;
  logic          squash_q, squash_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          timeout;
  logic          killed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      to_cnt_q <= '0;
      fl_cnt_q <= '0;
      squash_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      to_cnt_q <= to_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      squash_q <= squash_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // The counter value is the number of REQ/RESP cycles already spent, so the
  // cycle holding TIMEOUT_CYCLES-1 is the last one before the error is taken.
  assign timeout = (to_cnt_q >= TW'(TIMEOUT_CYCLES - 1));
  assign killed  = squash_q | lsu_flush;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    to_cnt_d = to_cnt_q;
    fl_cnt_d = fl_cnt_q;
    squash_d = squash_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        squash_d = 1'b0;
        if (lsu2dbus_st_req || lsu2dbus_ld_req) begin
          req_d.addr  = dbus_addr & 32'hFFFF_FFFC;
          req_d.be    = lsu2dbus_byte_enable;
          req_d.wdata = lsu2dbus_W_data;
          req_d.we    = lsu2dbus_st_req;
          to_cnt_d    = '0;
          err_d       = 1'b0;
          state_d     = REQ;
        end else if (dcache_flush) begin
          fl_cnt_d = FW'(FLUSH_CYCLES);
          err_d    = 1'b0;
          rdata_d  = '0;
          state_d  = FLUSH;
        end
      end
      REQ: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (mem_gnt) begin
          // Once granted the memory owes a response, so a flush only squashes.
          squash_d = lsu_flush;
          state_d  = RESP;
        end else if (lsu_flush) begin
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      RESP: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (lsu_flush) squash_d = 1'b1;
        if (mem_rvalid) begin
          if (killed) begin
            state_d = IDLE;
          end else begin
            rdata_d = req_q.we ? 32'h0 : mem_rdata;
            err_d   = 1'b0;
            state_d = DONE;
          end
        end else if (timeout) begin
          if (killed) begin
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      FLUSH: begin
        if (lsu_flush) begin
          state_d = IDLE;
        end else if (fl_cnt_q <= FW'(1)) begin
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          fl_cnt_d = fl_cnt_q - FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory handshake: a request transfers in any cycle where mem_req and
  // mem_gnt are both high; mem_req and its fields stay constant until then.
  // Exactly one mem_rvalid follows each transfer, no earlier than next cycle.
  assign mem_req    = (state_q == REQ);
  assign mem_we     = req_q.we;
  assign mem_addr   = req_q.addr;
  assign mem_be     = req_q.be;
  assign mem_wdata  = req_q.wdata;

  assign dbus_ack   = (state_q == DONE) && !lsu_flush;
  assign dbus_err   = dbus_ack && err_q;
  assign dbus_rdata = rdata_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_m_dbus_ctrl.sv
// Directed and randomized bench for m_dbus_ctrl with a transaction-level
// reference model of ack timing, data, error and memory-side behaviour.
module tb_m_dbus_ctrl;
  import m_pkg::*;

  localparam int T_CYC = 8;
  localparam int F_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_req, st_req, dcache_flush, lsu_flush;
  logic [31:0] dbus_addr, w_data;
  logic [3:0]  be;
  logic [31:0] dbus_rdata;
  logic        dbus_ack, dbus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  dbus_state_e state_dbg;

  m_dbus_ctrl #(.TIMEOUT_CYCLES(T_CYC), .FLUSH_CYCLES(F_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu2dbus_ld_req(ld_req), .lsu2dbus_st_req(st_req),
    .dbus_addr(dbus_addr), .lsu2dbus_byte_enable(be), .lsu2dbus_W_data(w_data),
    .dcache_flush(dcache_flush), .lsu_flush(lsu_flush),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .dbus_err(dbus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // observations collected by run_txn
  int          obs_req_cyc, obs_ack_cnt, obs_ack_cyc;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic        obs_err, obs_we, obs_stable, obs_consec, prev_ack;
  logic [3:0]  obs_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ld_req = 0; st_req = 0; dcache_flush = 0; lsu_flush = 0;
    mem_gnt = 0; mem_rvalid = 0;
  endtask

  // gw/rw < 0 mean the grant/response never comes; lsuf_c = cycle of lsu_flush (0 = none)
  task automatic run_txn(input bit ld, input bit st, input bit df, input logic [31:0] addr,
                         input logic [3:0] b, input logic [31:0] wd, input int gw, input int rw,
                         input logic [31:0] rd, input int lsuf_c, input int ncyc);
    @(posedge clk); #1;
    ld_req = ld; st_req = st; dcache_flush = df;
    dbus_addr = addr; be = b; w_data = wd;
    obs_req_cyc = 0; obs_ack_cnt = 0; obs_ack_cyc = -1; obs_rdata = 'x; obs_err = 'x;
    obs_stable = 1; obs_consec = 0; prev_ack = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      dbus_addr  = $urandom; be = 4'($urandom); w_data = $urandom;
      mem_gnt    = (gw >= 0) && (c == 1 + gw);
      mem_rvalid = (gw >= 0) && (rw >= 0) && (c == 2 + gw + rw);
      mem_rdata  = mem_rvalid ? rd : $urandom;
      lsu_flush  = (c == lsuf_c);
      if (c == lsuf_c) begin ld_req = 0; st_req = 0; dcache_flush = 0; end
      @(negedge clk);
      if (mem_req) begin
        if (obs_req_cyc == 0) begin
          obs_we = mem_we; obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
        end else if (mem_we !== obs_we || mem_addr !== obs_addr || mem_be !== obs_be ||
                     mem_wdata !== obs_wdata) begin
          obs_stable = 0;
        end
        obs_req_cyc++;
      end
      if (dbus_ack && prev_ack) obs_consec = 1;
      prev_ack = dbus_ack;
      if (dbus_ack) begin
        obs_ack_cnt++;
        if (obs_ack_cnt == 1) begin
          obs_ack_cyc = c; obs_rdata = dbus_rdata; obs_err = dbus_err;
        end
        ld_req = 0; st_req = 0; dcache_flush = 0;
      end
    end
    clear_inputs();
  endtask

  // Reference model works from the transaction description, not DUT state.
  task automatic do_txn(input string tag, input bit ld, input bit st, input bit df,
                        input logic [31:0] addr, input logic [3:0] b, input logic [31:0] wd,
                        input int gw, input int rw, input logic [31:0] rd, input int lsuf_c);
    int          e_ack_cnt, e_ack_cyc, e_req_cyc;
    logic [31:0] e_rdata;
    logic        e_err;
    bit          is_mem;
    is_mem = ld | st;
    run_txn(ld, st, df, addr, b, wd, gw, rw, rd, lsuf_c, 24);
    e_ack_cnt = 1; e_ack_cyc = 0; e_err = 0; e_rdata = 0; e_req_cyc = 0;
    if (!is_mem) begin
      e_ack_cyc = F_CYC + 1;
    end else if (lsuf_c > 0 && (gw < 0 || lsuf_c <= gw)) begin
      e_ack_cnt = 0; e_req_cyc = lsuf_c;
    end else if (lsuf_c > 0) begin
      e_ack_cnt = 0; e_req_cyc = gw + 1;
    end else if (gw >= 0 && rw >= 0 && gw + rw + 2 <= T_CYC) begin
      e_ack_cyc = gw + rw + 3; e_req_cyc = gw + 1; e_rdata = st ? 32'h0 : rd;
    end else begin
      e_ack_cyc = T_CYC + 1; e_err = 1; e_req_cyc = (gw < 0) ? T_CYC : gw + 1;
    end
    chk({tag, " req_cycles"}, 32'(obs_req_cyc), 32'(e_req_cyc));
    chk({tag, " ack_count"}, 32'(obs_ack_cnt), 32'(e_ack_cnt));
    chk({tag, " ack_consecutive"}, 32'(obs_consec), 32'h0);
    if (e_ack_cnt > 0) begin
      chk({tag, " ack_cycle"}, 32'(obs_ack_cyc), 32'(e_ack_cyc));
      chk({tag, " ack_err"}, 32'(obs_err), 32'(e_err));
      if (is_mem) chk({tag, " ack_rdata"}, obs_rdata, e_rdata);
    end
    if (e_req_cyc > 0) begin
      chk({tag, " mem_we"}, 32'(obs_we), 32'(st));
      chk({tag, " mem_addr"}, obs_addr, addr & 32'hFFFF_FFFC);
      chk({tag, " mem_be"}, 32'(obs_be), 32'(b));
      chk({tag, " mem_wdata"}, obs_wdata, wd);
      chk({tag, " fields_stable"}, 32'(obs_stable), 32'h1);
    end
  endtask

  initial begin
    int acks;
    rst_n = 0; clear_inputs();
    dbus_addr = 0; be = 0; w_data = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset mem_we", 32'(mem_we), 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_be", 32'(mem_be), 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset rdata", dbus_rdata, 0);
    chk("reset ack", 32'(dbus_ack), 0);
    chk("reset err", 32'(dbus_err), 0);
    @(posedge clk); #1 rst_n = 1;

    // directed steps
    do_txn("load_fast", 1, 0, 0, 32'h8000_0006, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF, 0);
    do_txn("store_gnt3", 0, 1, 0, 32'h0000_1000, 4'b0011, 32'h1234_5678, 3, 0, 32'hA5A5A5A5, 0);
    do_txn("ld_and_st", 1, 1, 0, 32'h0000_2008, 4'b1100, 32'hCAFE_F00D, 1, 1, 32'h1111_2222, 0);
    do_txn("no_gnt_timeout", 1, 0, 0, 32'h0000_3000, 4'hF, 32'h0, -1, -1, 32'h0, 0);
    do_txn("resp_timeout_late_rv", 1, 0, 0, 32'h0000_3004, 4'hF, 32'h0, 1, 10, 32'h5555_5555, 0);
    do_txn("flush_before_gnt", 1, 0, 0, 32'h0000_4000, 4'hF, 32'h0, -1, -1, 32'h0, 2);
    do_txn("flush_in_resp", 1, 0, 0, 32'h0000_4004, 4'hF, 32'h0, 0, 2, 32'h7777_7777, 2);
    do_txn("flush_on_gnt", 0, 1, 0, 32'h0000_4008, 4'h1, 32'h99, 1, 1, 32'h0, 2);
    do_txn("load_after_flush", 1, 0, 0, 32'h0000_400C, 4'hF, 32'h0, 2, 1, 32'h0BAD_CAFE, 0);
    do_txn("dcache_flush", 0, 0, 1, 32'h0, 4'h0, 32'h0, -1, -1, 32'h0, 0);
    do_txn("ld_over_dcache_flush", 1, 0, 1, 32'h0000_5001, 4'hF, 32'h0, 0, 1, 32'h1357_9BDF, 0);

    // reset during RESP, late rvalid must be discarded
    @(posedge clk); #1;
    ld_req = 1; dbus_addr = 32'h0000_6000; be = 4'hF; w_data = 32'h0;
    @(posedge clk); #1 mem_gnt = 1;
    @(posedge clk); #1 mem_gnt = 0; rst_n = 0; ld_req = 0;
    @(posedge clk); #1 rst_n = 1; mem_rvalid = 1; mem_rdata = 32'hFEED_FACE;
    @(negedge clk);
    chk("rst_resp mem_req", 32'(mem_req), 0);
    chk("rst_resp mem_addr", mem_addr, 0);
    chk("rst_resp mem_be", 32'(mem_be), 0);
    chk("rst_resp rdata", dbus_rdata, 0);
    chk("rst_resp ack", 32'(dbus_ack), 0);
    acks = 0;
    @(posedge clk); #1 mem_rvalid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dbus_ack) acks++;
      @(posedge clk); #1;
    end
    chk("rst_resp late_rvalid_acks", 32'(acks), 0);

    // randomized transactions
    for (int i = 0; i < 24; i++) begin
      int kind, gw, rw;
      bit ld, st, df;
      kind = $urandom_range(0, 9);
      ld = (kind < 5) || (kind == 8);
      st = (kind >= 5);
      df = (kind == 9) ? 1'b0 : 1'($urandom_range(0, 1));
      if (kind == 9) begin ld = 0; st = 0; df = 1; end
      gw = $urandom_range(0, 3);
      rw = ($urandom_range(0, 5) == 0) ? 10 : $urandom_range(0, 3);
      do_txn($sformatf("rand%0d", i), ld, st, df, $urandom, 4'($urandom), $urandom,
             gw, rw, $urandom, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/m_dbus_ctrl.md
# m_dbus_ctrl

Data-bus controller directly downstream of the load/store unit. Turns the LSU's level-held load/store/dcache-flush requests into a single-outstanding request/grant/response transaction on the data memory port. Returns registered read data and a one-cycle acknowledge to the LSU and hazard unit. Also provides a bus timeout and clean abort on pipeline flush.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: cycles in REQ+RESP before a bus error; must be ≥2
- FLUSH_CYCLES, 2: fixed latency of a dcache flush acknowledge (no cache yet); must be ≥1

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- lsu2dbus_ld_req  in  1  load request, held by LSU until dbus_ack
- lsu2dbus_st_req  in  1  store request, held until dbus_ack
- dbus_addr  in  32  physical address
- lsu2dbus_byte_enable  in  4  byte lanes
- lsu2dbus_W_data  in  32  store data
- dcache_flush  in  1  flush request, held until dbus_ack
- lsu_flush  in  1  pipeline flush from hazard unit
- dbus_rdata  out  32  registered load data
- dbus_ack  out  1  one-cycle completion pulse
- dbus_err  out  1  valid with dbus_ack; 1 = timeout
- mem_req  out  1  request valid to memory
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits [1:0] forced 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  write data
- mem_gnt  in  1  memory accepts request (handshake mem_req & mem_gnt)
- mem_rvalid  in  1  response valid, earliest one cycle after grant, one per granted request
- mem_rdata  in  32  response data

## Operation
- States: IDLE, REQ, RESP, DONE, FLUSH.
- IDLE: store request has priority over load. When both are high, the block treats the request as a store. On st_req or ld_req it latches addr/be/wdata/we → REQ, and clears the timeout counter. On dcache_flush with no ld/st request it loads the flush counter → FLUSH.
- REQ: mem_req=1 with the latched fields. On mem_gnt → RESP.
- RESP: mem_req=0. On mem_rvalid, rdata_q takes mem_rdata (load) or 0 (store) → DONE.
- DONE: dbus_ack=1 and dbus_err=err_q for exactly this cycle; incoming requests are ignored. Next state is IDLE.
- FLUSH: counter decrements each cycle; at 1 → DONE with err=0.
- Timeout: the counter increments in REQ and RESP. On reaching TIMEOUT_CYCLES the block goes to DONE with err_q=1, rdata_q=0 and drops mem_req. A mem_rvalid arriving in IDLE is discarded.
- lsu_flush:
  - In REQ without gnt in the same cycle: drop mem_req → IDLE, no ack.
  - In REQ with gnt, or in RESP: set squash_q and keep waiting for mem_rvalid (or timeout), then → IDLE with no ack.
  - In DONE: dbus_ack is masked combinationally that cycle.
  - In FLUSH: → IDLE, no ack.
- Store data and byte enables are passed through unchanged. Load lane extraction and sign extension are not done here.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, dbus_rdata=0, dbus_ack=0, dbus_err=0, squash_q=0, both counters 0. Reset mid-transaction abandons it; a later rvalid is discarded in IDLE.
- Minimum load/store latency (request to ack):
  - Request seen at edge 0.
  - mem_req high in cycle 1; gnt in cycle 1.
  - rvalid in cycle 2.
  - dbus_ack and dbus_rdata valid in cycle 3.
- Each grant wait cycle and each rvalid wait cycle adds one cycle.
- dbus_ack is never high in two consecutive cycles. A new request is accepted no earlier than the cycle after DONE.
- mem_req and its fields are stable from assertion until the gnt cycle.
- Flush ack latency: dcache_flush at edge 0 → ack in cycle FLUSH_CYCLES+1.

## Structure
- Shared package m_pkg holds:
  - the dbus_state_e enum (IDLE, REQ, RESP, DONE, FLUSH)
  - a dbus_req_t struct {addr, be, wdata, we}
  - DBUS_TIMEOUT_DEFAULT
- No sub-module. One FSM plus the latched-request register, a timeout counter of width $clog2(TIMEOUT_CYCLES+1), the flush counter and squash_q.

## Test plan
- Load, gnt immediate, rvalid at cycle 2 with mem_rdata=32'hDEADBEEF, addr 32'h8000_0006 → mem_addr=32'h8000_0004; dbus_ack pulse in cycle 3 with dbus_rdata=32'hDEADBEEF, dbus_err=0.
- Store with be=4'b0011, wdata=32'h1234_5678, gnt delayed 3 cycles → mem_req held with stable fields 4 cycles; ack in cycle 6; dbus_rdata=0.
- ld_req and st_req both high → mem_we=1 observed; exactly one ack.
- No gnt, TIMEOUT_CYCLES=8 → mem_req drops after 8 cycles; ack with dbus_err=1, rdata=0; a later rvalid is ignored and there is no second ack.
- lsu_flush in REQ before gnt → mem_req low next cycle, no ack. lsu_flush in RESP → rvalid consumed, no ack. A new load afterwards completes normally.
- dcache_flush with FLUSH_CYCLES=2 → ack in cycle 3, no mem_req. rst_n low during RESP → all outputs at reset values next cycle.
